// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default frame constants,
// and helpers reused by the transmit and (future) receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_STOP_BITS = 1;
  localparam int unsigned UART_CNT_W     = 3;

  // Bit periods from the first baud tick after acceptance to the stop-end tick.
  function automatic int unsigned frame_ticks(input int unsigned data_bits,
                                              input int unsigned parity_en,
                                              input int unsigned stop_bits);
    return 32'd1 + data_bits + parity_en + stop_bits;
  endfunction

  // Payload is zero-extended to 8 bits, so narrower words give the same result.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmit serializer: accepts a word on a valid/ready handshake and shifts
// it out LSB first framed by start, optional parity and stop bits, one bit per baud tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = UART_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam logic [UART_CNT_W-1:0] LastData = UART_CNT_W'(DATA_BITS - 1);
  localparam logic [UART_CNT_W-1:0] LastStop = UART_CNT_W'(STOP_BITS - 1);

  uart_state_e            state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [UART_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;

  // State and datapath registers; reset forces the line idle-high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next state; tx_d is the level the line must carry in the state being entered.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    tx_d    = tx_q;

    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (tx_valid && ready_q) begin
          shift_d = tx_data;
          par_d   = parity_bit(8'(tx_data), 1'(PARITY_ODD));
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (cnt_q == LastData) begin
            cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + UART_CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          if (cnt_q == LastStop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + UART_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        cnt_d   = '0;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations driven from one baud tick, checked
// every cycle against a frame-level model plus hand-written line patterns.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  int         tick_cnt;
  logic [3:0] valid;
  logic [7:0] data [4];
  logic [3:0] rdy_w, tx_w, busy_w;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 0;

  // Model state: frame as a list of line levels, idx = -1 when idle.
  int          idx   [4];
  logic [15:0] fr    [4];
  logic        m_rdy [4];

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data[3]), .tx_valid(valid[3]),
    .tx_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

  function automatic int pe(input int k);
    return (k == 1 || k == 2) ? 1 : 0;
  endfunction
  function automatic int po(input int k);
    return (k == 2) ? 1 : 0;
  endfunction
  function automatic int sb(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  // Levels: [0] idle wait, [1] start, [2..9] data LSB first, then parity, then stops.
  function automatic logic [15:0] build_frame(input int k, input logic [7:0] d);
    logic [15:0] f;
    f    = '1;
    f[1] = 1'b0;
    for (int i = 0; i < 8; i++) f[2+i] = d[i];
    if (pe(k) == 1) f[10] = (($countones(d) % 2) == 1) ^ (po(k) == 1);
    return f;
  endfunction

  function automatic int flen(input int k);
    return 10 + pe(k) + sb(k);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        idx[k]   <= -1;
        m_rdy[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (idx[k] == -1) begin
          if (m_rdy[k] && valid[k]) begin
            fr[k]    <= build_frame(k, data[k]);
            idx[k]   <= 0;
            m_rdy[k] <= 1'b0;
          end else begin
            m_rdy[k] <= 1'b1;
          end
        end else if (baud_tick) begin
          if (idx[k] + 1 == flen(k)) begin
            idx[k]   <= -1;
            m_rdy[k] <= 1'b1;
          end else begin
            idx[k] <= idx[k] + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        logic e_tx;
        e_tx = (idx[k] < 0) ? 1'b1 : fr[k][idx[k]];
        chk($sformatf("model_tx%0d", k), tx_w[k], e_tx);
        chk($sformatf("model_ready%0d", k), rdy_w[k], m_rdy[k]);
        chk($sformatf("model_busy%0d", k), busy_w[k], idx[k] != -1);
      end
    end
  end

  initial begin
    baud_tick = 1'b0;
    tick_cnt  = 0;
    forever begin
      @(negedge clk);
      baud_tick = (tick_cnt == 3);
      tick_cnt  = (tick_cnt + 1) % 4;
    end
  end

  task automatic wait_tick(output int polls, output bit got);
    polls = 0;
    got   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      polls++;
      if (baud_tick) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_req(input int k, input logic [7:0] d);
    @(posedge clk);
    #1;
    valid[k] = 1'b1;
    data[k]  = d;
  endtask

  task automatic wait_accept(input int k, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (idx[k] != -1) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_accept"}, ok, 1'b1);
  endtask

  task automatic drop(input int k);
    valid[k] = 1'b0;
    data[k]  = ~data[k];
  endtask

  // Sample the line one half-cycle after each tick and compare to a literal pattern.
  task automatic check_line(input int k, input string name, input string bits,
                            output int first_wait);
    int polls;
    bit got;
    first_wait = 0;
    for (int b = 0; b < bits.len(); b++) begin
      wait_tick(polls, got);
      if (b == 0) first_wait = polls;
      chk($sformatf("%s_tick%0d", name, b), got, 1'b1);
      if (!got) return;
      @(negedge clk);
      chk($sformatf("%s_bit%0d", name, b), tx_w[k], bits[b] == "1");
    end
    wait_tick(polls, got);
    chk({name, "_endtick"}, got, 1'b1);
    @(negedge clk);
    chk({name, "_ready_after"}, rdy_w[k], 1'b1);
    chk({name, "_busy_after"}, busy_w[k], 1'b0);
  endtask

  task automatic do_frame(input int k, input logic [7:0] d, input string name,
                          input string bits);
    int fw;
    start_req(k, d);
    wait_accept(k, name);
    drop(k);
    check_line(k, name, bits, fw);
  endtask

  initial begin
    int  fw;
    bit  got;
    int  polls;
    valid = '0;
    for (int k = 0; k < 4; k++) data[k] = 8'h00;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset_tx", tx_w[0], 1'b1);
    chk("reset_ready", rdy_w[0], 1'b0);
    chk("reset_busy", busy_w[0], 1'b0);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 chk("ready_before_edge", rdy_w[0], 1'b0);
    @(posedge clk);
    #1 chk("ready_first_edge", rdy_w[0], 1'b1);

    do_frame(0, 8'h55, "f55",        "0101010101");
    do_frame(1, 8'h07, "f07_even",   "01110000011");
    do_frame(2, 8'h07, "f07_odd",    "01110000001");
    do_frame(3, 8'h80, "f80_stop2",  "00000000111");

    // Handshake coincident with a tick: that tick must not start the frame.
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (tick_cnt == 3) begin
        got = 1'b1;
        break;
      end
    end
    chk("align_found", got, 1'b1);
    valid[0] = 1'b1;
    data[0]  = 8'hC6;
    wait_accept(0, "fC6");
    drop(0);
    check_line(0, "fC6", "0011000111", fw);
    chk_int("fC6_start_delay", fw, 4);

    // Back-to-back with tx_valid held; second byte presented while first is busy.
    start_req(0, 8'hA3);
    wait_accept(0, "fA3");
    data[0] = 8'h3C;
    check_line(0, "fA3", "0110001011", fw);
    wait_accept(0, "f3C");
    drop(0);
    check_line(0, "f3C", "0001111001", fw);
    chk_int("f3C_start_delay", fw, 3);

    // Reset during data bit 3 of 0xFF, then a clean 0x00 frame.
    start_req(0, 8'hFF);
    wait_accept(0, "fFF");
    drop(0);
    for (int i = 0; i < 5; i++) begin
      wait_tick(polls, got);
      chk($sformatf("fFF_tick%0d", i), got, 1'b1);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tx", tx_w[0], 1'b1);
    chk("midrst_busy", busy_w[0], 1'b0);
    chk("midrst_ready", rdy_w[0], 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 chk("midrst_ready_edge", rdy_w[0], 1'b1);
    do_frame(0, 8'h00, "f00", "0000000001");

    repeat (10) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
